// File: rtl/bp_stream_axil_pkg.sv
// Shared state encodings and AXI response codes for the stream AXI-Lite adapter.
package bp_stream_axil_pkg;

    typedef enum logic [1:0] {
        e_w_idle = 2'd0,
        e_w_fwd  = 2'd1,
        e_w_resp = 2'd2
    } w_state_e;

    typedef enum logic {
        e_r_idle = 1'b0,
        e_r_resp = 1'b1
    } r_state_e;

    localparam logic [1:0] resp_okay_c   = 2'b00;
    localparam logic [1:0] resp_slverr_c = 2'b10;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small power-of-two FIFO: valid/ready on the write side, valid/yumi on the read side,
// with an occupancy counter exposed for host polling.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 16,
    localparam int ptr_w  = $clog2(els_p),
    localparam int cnt_w  = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [cnt_w-1:0]   count_o
);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr, wptr;
    logic [cnt_w-1:0]   count;
    logic               push, pop;

    assign ready_o = (count != cnt_w'(els_p));
    assign v_o     = (count != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem[rptr];
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wptr] <= data_i;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + ptr_w'(1);
            if (pop)
                rptr <= rptr + ptr_w'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_stream_axil_adapter.sv
// AXI4-Lite slave that forwards host writes as (addr, data) stream words and lets the
// host drain the response stream through polled reads of a data and a count address.
module bp_stream_axil_adapter
    import bp_stream_axil_pkg::*;
#(
    parameter int axil_addr_width_p   = 32,
    parameter int axil_data_width_p   = 32,
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter int rd_fifo_els_p       = 16,
    parameter logic [axil_addr_width_p-1:0] rd_data_addr_p  = 32'h00000020,
    parameter logic [axil_addr_width_p-1:0] rd_count_addr_p = 32'h00000024
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic                           stream_v_o,
    output logic [stream_addr_width_p-1:0] stream_addr_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o
);

    localparam int cnt_w = $clog2(rd_fifo_els_p + 1);

    w_state_e w_state;
    r_state_e r_state;

    logic                           aw_held, w_held;
    logic [axil_addr_width_p-1:0]   awaddr_q;
    logic [axil_data_width_p-1:0]   wdata_q;
    logic [axil_data_width_p/8-1:0] wstrb_q, wstrb_nx;
    logic                           awready_q, wready_q, bvalid_q, stream_v_q;
    logic [1:0]                     bresp_q;
    logic                           aw_hs, w_hs, aw_held_nx, w_held_nx;

    logic                           arready_q, rvalid_q;
    logic [axil_data_width_p-1:0]   rdata_q;
    logic [1:0]                     rresp_q;
    logic                           ar_hs, is_data, is_count, fifo_pop;

    logic                           fifo_v;
    logic [stream_data_width_p-1:0] fifo_data;
    logic [cnt_w-1:0]               fifo_count;

    assign aw_hs      = s_axil_awvalid_i & awready_q;
    assign w_hs       = s_axil_wvalid_i & wready_q;
    assign aw_held_nx = aw_held | aw_hs;
    assign w_held_nx  = w_held | w_hs;
    assign wstrb_nx   = w_hs ? s_axil_wstrb_i : wstrb_q;

    // The strobe check looks at the incoming strobe when W completes this cycle,
    // so a same-cycle AW/W pair can forward on the very next cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state    <= e_w_idle;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= resp_okay_c;
            stream_v_q <= 1'b0;
        end else begin
            case (w_state)
                e_w_idle: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        awaddr_q  <= s_axil_awaddr_i;
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        wdata_q  <= s_axil_wdata_i;
                        wstrb_q  <= s_axil_wstrb_i;
                        wready_q <= 1'b0;
                    end
                    if (aw_held_nx && w_held_nx) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (&wstrb_nx) begin
                            stream_v_q <= 1'b1;
                            w_state    <= e_w_fwd;
                        end else begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= resp_slverr_c;
                            w_state  <= e_w_resp;
                        end
                    end
                end
                e_w_fwd: begin
                    if (stream_yumi_i) begin
                        stream_v_q <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= resp_okay_c;
                        w_state    <= e_w_resp;
                    end
                end
                e_w_resp: begin
                    if (s_axil_bready_i) begin
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= e_w_idle;
                    end
                end
                default: w_state <= e_w_idle;
            endcase
        end
    end

    assign ar_hs    = s_axil_arvalid_i & arready_q;
    assign is_data  = (s_axil_araddr_i == rd_data_addr_p);
    assign is_count = (s_axil_araddr_i == rd_count_addr_p);
    assign fifo_pop = ar_hs & is_data & fifo_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= e_r_idle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= resp_okay_c;
        end else begin
            case (r_state)
                e_r_idle: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_state   <= e_r_resp;
                        if (is_data) begin
                            rdata_q <= fifo_v ? fifo_data : '0;
                            rresp_q <= resp_okay_c;
                        end else if (is_count) begin
                            rdata_q <= axil_data_width_p'(fifo_count);
                            rresp_q <= resp_okay_c;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= resp_slverr_c;
                        end
                    end
                end
                e_r_resp: begin
                    if (s_axil_rready_i) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= e_r_idle;
                    end
                end
                default: r_state <= e_r_idle;
            endcase
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (stream_data_width_p),
        .els_p   (rd_fifo_els_p)
    ) rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (stream_v_i),
        .data_i  (stream_data_i),
        .ready_o (stream_ready_o),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_pop),
        .count_o (fifo_count)
    );

    assign s_axil_awready_o = awready_q;
    assign s_axil_wready_o  = wready_q;
    assign s_axil_bvalid_o  = bvalid_q;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_arready_o = arready_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign stream_v_o       = stream_v_q;
    assign stream_addr_o    = awaddr_q[stream_addr_width_p-1:0];
    assign stream_data_o    = wdata_q;

endmodule

// File: tb/tb_bp_stream_axil_adapter.sv
// Directed bench for the stream AXI-Lite adapter: stimulus pushes expected stream words,
// write responses and read responses into queues that handshake monitors drain.
module tb_bp_stream_axil_adapter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] awaddr, wdata, araddr, rdata, stream_addr, stream_data, stream_rsp_data;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        stream_v, stream_yumi, stream_rsp_v, stream_ready;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_stream[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    always #5 clk = ~clk;

    bp_stream_axil_adapter dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .stream_v_o       (stream_v),
        .stream_addr_o    (stream_addr),
        .stream_data_o    (stream_data),
        .stream_yumi_i    (stream_yumi),
        .stream_v_i       (stream_rsp_v),
        .stream_data_i    (stream_rsp_data),
        .stream_ready_o   (stream_ready)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s unexpected handshake got=%0h at %0t", name, act, $time);
    endfunction

    // Handshake monitors
    always @(negedge clk) begin
        if (!reset_i) begin
            if (stream_v && stream_yumi) begin
                if (exp_stream.size() == 0) unexpected("stream_word", {stream_addr, stream_data});
                else chk("stream_word", {stream_addr, stream_data}, exp_stream.pop_front());
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) unexpected("bresp", 64'(bresp));
                else chk("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) unexpected("rdata_rresp", {rresp, rdata});
                else chk("rdata_rresp", 64'({rresp, rdata}), 64'(exp_r.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic axil_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        exp_r.push_back({er, ed});
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            total++; bad++;
            $display("FAIL ar_accept timeout addr=%0h", a);
        end
        cyc();
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            total++; bad++;
            $display("FAIL rvalid timeout addr=%0h", a);
        end
        cyc();
    endtask

    initial begin
        #200000;
        total++; bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset_i = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 1;
        stream_yumi = 0; stream_rsp_v = 0; stream_rsp_data = '0;
        repeat (2) cyc();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_awready", 64'(awready), 1);
        chk("rst_wready", 64'(wready), 1);
        chk("rst_arready", 64'(arready), 1);
        chk("rst_valids", 64'({bvalid, rvalid, stream_v}), 0);
        chk("rst_resp_data", 64'({bresp, rresp, rdata}), 0);
        chk("rst_stream_ready", 64'(stream_ready), 1);

        // same-cycle AW/W, yumi ready in cycle 1
        cyc();
        stream_yumi = 1;
        awaddr = 32'h10; awvalid = 1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        exp_stream.push_back({32'h10, 32'hDEADBEEF});
        exp_b.push_back(2'b00);
        @(negedge clk);
        chk("t1_aw_accept", 64'({awready, wready}), 64'b11);
        cyc();
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("t1_stream_v_c1", 64'(stream_v), 1);
        chk("t1_bvalid_c1", 64'(bvalid), 0);
        cyc();
        @(negedge clk);
        chk("t1_bvalid_c2", 64'(bvalid), 1);
        chk("t1_stream_v_c2", 64'(stream_v), 0);
        cyc();

        // W two cycles ahead of AW, yumi withheld for 5 cycles
        stream_yumi = 0;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        exp_stream.push_back({32'h44, 32'h12345678});
        exp_b.push_back(2'b00);
        @(negedge clk);
        chk("t2_w_accept", 64'(wready), 1);
        cyc();
        wvalid = 0;
        @(negedge clk);
        chk("t2_wready_drop", 64'(wready), 0);
        chk("t2_awready_wait", 64'(awready), 1);
        cyc();
        awaddr = 32'h44; awvalid = 1;
        @(negedge clk);
        chk("t2_aw_accept", 64'(awready), 1);
        cyc();
        awvalid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stream_stable", 64'({stream_v, stream_addr, stream_data}), {31'd0, 1'b1, 32'h44, 32'h12345678});
            cyc();
        end
        stream_yumi = 1;
        @(negedge clk);
        chk("t2_bvalid_before_yumi", 64'(bvalid), 0);
        cyc();
        stream_yumi = 0;
        @(negedge clk);
        chk("t2_bvalid_after_yumi", 64'({bvalid, stream_v}), 64'b10);
        cyc();
        @(negedge clk);
        chk("t2_bvalid_cleared", 64'(bvalid), 0);
        cyc();

        // partial strobe: SLVERR, nothing forwarded
        stream_yumi = 1;
        awaddr = 32'h8; awvalid = 1;
        wdata = 32'hCAFEF00D; wstrb = 4'h3; wvalid = 1;
        exp_b.push_back(2'b10);
        cyc();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_no_stream", 64'(stream_v), 0);
            cyc();
        end
        stream_yumi = 0;

        // three response words then drain
        for (int i = 1; i <= 3; i++) begin
            stream_rsp_v = 1; stream_rsp_data = 32'(i);
            @(negedge clk);
            chk("t4_push_ready", 64'(stream_ready), 1);
            cyc();
        end
        stream_rsp_v = 0;
        axil_read(32'h24, 32'd3, 2'b00);
        axil_read(32'h20, 32'd1, 2'b00);
        axil_read(32'h20, 32'd2, 2'b00);
        axil_read(32'h20, 32'd3, 2'b00);
        axil_read(32'h20, 32'd0, 2'b00);

        // fill to full, one pop frees a slot
        for (int i = 0; i < 16; i++) begin
            stream_rsp_v = 1; stream_rsp_data = 32'(100 + i);
            @(negedge clk);
            chk("t5_fill_ready", 64'(stream_ready), 1);
            cyc();
        end
        stream_rsp_v = 0;
        @(negedge clk);
        chk("t5_full_ready", 64'(stream_ready), 0);
        exp_r.push_back({2'b00, 32'd100});
        araddr = 32'h20; arvalid = 1;
        cyc();
        arvalid = 0;
        @(negedge clk);
        chk("t5_ready_after_pop", 64'(stream_ready), 1);
        cyc();
        axil_read(32'h24, 32'd15, 2'b00);

        // unmapped read
        axil_read(32'h30, 32'd0, 2'b10);

        // reset while forwarding
        stream_yumi = 0;
        awaddr = 32'h50; awvalid = 1;
        wdata = 32'hAA; wstrb = 4'hF; wvalid = 1;
        cyc();
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("t6_in_fwd", 64'(stream_v), 1);
        reset_i = 1;
        cyc();
        reset_i = 0;
        @(negedge clk);
        chk("t6_rst_stream_v", 64'(stream_v), 0);
        chk("t6_rst_awready", 64'({awready, wready}), 64'b11);
        chk("t6_rst_bvalid", 64'(bvalid), 0);
        cyc();
        axil_read(32'h24, 32'd0, 2'b00);

        repeat (3) cyc();
        chk("sb_stream_empty", 64'(exp_stream.size()), 0);
        chk("sb_b_empty", 64'(exp_b.size()), 0);
        chk("sb_r_empty", 64'(exp_r.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
